// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts bytes over a valid/ready handshake, serialises
// each one MSB first at one bit per cycle, and compares a sliding bit history
// against a programmable pattern of 1..8 bits. Detections produce a one-cycle
// match pulse, a saturating count and a sticky interrupt flag.
module pattern_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             irq_ack,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_nxt;
  logic [2:0] k;
  logic [7:0] data_buf;
  logic [7:0] hist;
  logic [3:0] seen;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       overlap;

  logic       handshake;
  logic       bit_fire;
  logic       bit_in;
  logic [7:0] hist_upd;
  logic [3:0] seen_upd;
  logic [7:0] len_mask;
  logic       det;

  // Per-bit datapath: next history, saturating seen count and the detection.
  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    handshake = 1'b0;
    bit_fire  = 1'b0;
    bit_in    = 1'b0;
    hist_upd  = hist;
    seen_upd  = seen;
    len_mask  = 8'h00;
    det       = 1'b0;

    handshake = (state == IDLE) && in_valid;
    // A flush on a shift cycle discards the bit, so it never reaches the history.
    bit_fire  = (state == SHIFT) && !flush;
    bit_in    = data_buf[3'd7 - k];
    hist_upd  = {hist[6:0], bit_in};
    seen_upd  = (seen >= 4'd8) ? 4'd8 : seen + 4'd1;
    // len is stored already clamped to 0..8; len 0 yields an empty mask.
    len_mask  = 8'hFF >> (4'd8 - len);
    det       = bit_fire && (len != 4'd0) && (seen_upd >= len) &&
                (((hist_upd ^ pattern) & len_mask) == 8'h00);
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state and handshake outputs: one byte per 9 cycles.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (k == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte buffer, bit index, configuration and bit history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_buf <= 8'h00;
      k        <= 3'd0;
      hist     <= 8'h00;
      seen     <= 4'd0;
      pattern  <= 8'h00;
      len      <= 4'd0;
      overlap  <= 1'b0;
    end else begin
      if (handshake) begin
        data_buf <= in_data;
        k        <= 3'd0;
      end else if (state == SHIFT) begin
        k <= k + 3'd1;
      end

      if (state == IDLE) begin
        if (cfg_we) begin
          pattern <= cfg_pattern;
          len     <= (cfg_len > 4'd8) ? 4'd8 : cfg_len;
          overlap <= cfg_overlap;
        end
        if (cfg_we || flush) begin
          hist <= 8'h00;
          seen <= 4'd0;
        end
      end else if (flush) begin
        hist <= 8'h00;
        seen <= 4'd0;
      end else begin
        hist <= hist_upd;
        seen <= (det && !overlap) ? 4'd0 : seen_upd;
      end
    end
  end

  // Detection outputs: match pulse, saturating counter (clear wins), sticky irq (set wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      match <= det;
      if (cnt_clr)                      match_cnt <= '0;
      else if (det && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
      if (det)          irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pattern_scan_ctrl;

  localparam int CNT_W = 8;

  localparam int P_NONE  = 0;
  localparam int P_CFG   = 1;
  localparam int P_RST   = 2;
  localparam int P_CLR   = 3;
  localparam int P_FLUSH = 4;
  localparam int P_ACK   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic             cfg_we = 1'b0;
  logic [7:0]       cfg_pattern = 8'h00;
  logic [3:0]       cfg_len = 4'd0;
  logic             cfg_overlap = 1'b0;
  logic             flush = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             irq_ack = 1'b0;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;

  int checks = 0;
  int failures = 0;

  pattern_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .flush       (flush),
    .cnt_clr     (cnt_clr),
    .irq_ack     (irq_ack),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Program the configuration with a one-cycle write strobe (block is idle).
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_we      = 1'b1;
    @(posedge clk); #1;
    cfg_we      = 1'b0;
  endtask

  // Single-cycle strobe on cnt_clr or irq_ack while idle.
  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
  endtask

  // Send one byte; mask[k] records match sampled after the edge consuming bit k.
  // An optional side action is applied on the cycle that consumes bit poke_k.
  task automatic send_byte(input logic [7:0] d, input int poke_k, input int poke_kind,
                           output logic [7:0] mask, output logic [CNT_W-1:0] cnt_at_poke,
                           output int waited, output logic hs_busy);
    waited      = 0;
    mask        = 8'h00;
    cnt_at_poke = '0;
    hs_busy     = 1'b0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    hs_busy  = busy;
    for (int k = 0; k < 8; k++) begin
      if (k == poke_k) begin
        case (poke_kind)
          P_CFG: begin
            cfg_we      = 1'b1;
            cfg_pattern = 8'h03;
            cfg_len     = 4'd2;
            cfg_overlap = 1'b0;
          end
          P_RST: begin
            rst = 1'b1;
            #1;
            return;
          end
          P_CLR:   cnt_clr = 1'b1;
          P_FLUSH: flush   = 1'b1;
          P_ACK:   irq_ack = 1'b1;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      cfg_we  = 1'b0;
      cnt_clr = 1'b0;
      flush   = 1'b0;
      irq_ack = 1'b0;
      mask[k] = match;
      if (k == poke_k) cnt_at_poke = match_cnt;
    end
  endtask

  logic [7:0]       mask;
  logic [CNT_W-1:0] cap;
  int               waited;
  logic             hsb;

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, busy, match, irq} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got ready/busy/match/irq=%b required 1000", {in_ready, busy, match, irq});
    end
    checks++;
    if (match_cnt !== '0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d required 0", match_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    // Reset config has len 0: a byte of all ones produces no detection.
    send_byte(8'hFF, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h00) begin
      failures++;
      $display("FAIL reset_cfg_disabled mask got=%h required 00", mask);
    end
  endtask

  task automatic test_overlap();
    cfg(8'h15, 4'd5, 1'b1);
    send_byte(8'hAA, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h50) begin
      failures++;
      $display("FAIL overlap_mask got=%h required 50", mask);
    end
    checks++;
    if (match_cnt !== 8'd2 || irq !== 1'b1) begin
      failures++;
      $display("FAIL overlap_cnt_irq got cnt=%0d irq=%b required cnt=2 irq=1", match_cnt, irq);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL overlap_idle got busy=%b ready=%b required 0 1", busy, in_ready);
    end
    pulse_ack();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_ack got=%b required 0", irq);
    end
    pulse_clr();
    checks++;
    if (match_cnt !== '0) begin
      failures++;
      $display("FAIL cnt_clr_idle got=%0d required 0", match_cnt);
    end
  endtask

  task automatic test_non_overlap();
    cfg(8'h15, 4'd5, 1'b0);
    send_byte(8'hAA, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h10) begin
      failures++;
      $display("FAIL nonoverlap_mask got=%h required 10", mask);
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL nonoverlap_cnt got=%0d required 1", match_cnt);
    end
    pulse_clr();
  endtask

  task automatic test_cross_byte();
    cfg(8'h09, 4'd4, 1'b1);
    send_byte(8'h01, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h00) begin
      failures++;
      $display("FAIL cross_first_mask got=%h required 00", mask);
    end
    send_byte(8'h20, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h04) begin
      failures++;
      $display("FAIL cross_second_mask got=%h required 04", mask);
    end
    checks++;
    if (match_cnt !== 8'd1) begin
      failures++;
      $display("FAIL cross_cnt got=%0d required 1", match_cnt);
    end
    pulse_clr();
  endtask

  task automatic test_len_limits();
    // cfg_len 15 clamps to 8: the full byte matches once eight bits are seen.
    cfg(8'hAA, 4'd15, 1'b0);
    send_byte(8'hAA, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h80) begin
      failures++;
      $display("FAIL len_clamp_mask got=%h required 80", mask);
    end
    cfg(8'hFF, 4'd0, 1'b1);
    send_byte(8'hFF, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h00) begin
      failures++;
      $display("FAIL len_zero_mask got=%h required 00", mask);
    end
    pulse_clr();
  endtask

  task automatic test_flush_and_irq();
    cfg(8'h15, 4'd5, 1'b1);
    // Flush on bit 4 discards it; bits 5..7 alone are too short to match.
    send_byte(8'hAA, 4, P_FLUSH, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h00) begin
      failures++;
      $display("FAIL flush_mask got=%h required 00", mask);
    end
    cfg(8'h15, 4'd5, 1'b1);
    pulse_ack();
    // irq_ack lands on the k=6 detection: the set must win.
    send_byte(8'hAA, 6, P_ACK, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h50 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_set_wins got mask=%h irq=%b required 50 1", mask, irq);
    end
    pulse_clr();
  endtask

  task automatic test_saturation();
    cfg(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 32; i++) send_byte(8'hFF, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (match_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_reach got=%0d required 255", match_cnt);
    end
    send_byte(8'hFF, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (match_cnt !== 8'd255 || mask !== 8'hFF) begin
      failures++;
      $display("FAIL sat_hold got cnt=%0d mask=%h required 255 ff", match_cnt, mask);
    end
    send_byte(8'hFF, 0, P_CLR, mask, cap, waited, hsb);
    checks++;
    if (cap !== '0 || mask[0] !== 1'b1) begin
      failures++;
      $display("FAIL clr_wins got cnt=%0d match=%b required 0 1", cap, mask[0]);
    end
    checks++;
    if (match_cnt !== 8'd7) begin
      failures++;
      $display("FAIL clr_recount got=%0d required 7", match_cnt);
    end
  endtask

  task automatic test_back_to_back_cfg_busy();
    cfg(8'h15, 4'd5, 1'b1);
    pulse_clr();
    send_byte(8'hAA, 3, P_CFG, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h50 || match_cnt !== 8'd2) begin
      failures++;
      $display("FAIL cfg_busy got mask=%h cnt=%0d required 50 2", mask, match_cnt);
    end
  endtask

  task automatic test_reset_mid_shift();
    // Config still 0x15/5/overlap; rst hits while the k=4 match pulse is high.
    send_byte(8'hAA, 5, P_RST, mask, cap, waited, hsb);
    checks++;
    if ({in_ready, busy, match, irq} !== 4'b1000 || match_cnt !== '0) begin
      failures++;
      $display("FAIL rst_mid got ready/busy/match/irq=%b cnt=%0d required 1000 0",
               {in_ready, busy, match, irq}, match_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h00, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (waited !== 0 || hsb !== 1'b1) begin
      failures++;
      $display("FAIL rst_first_hs got waited=%0d busy=%b required 0 1", waited, hsb);
    end
    cfg(8'h15, 4'd5, 1'b1);
    send_byte(8'hAA, -1, P_NONE, mask, cap, waited, hsb);
    checks++;
    if (mask !== 8'h50 || match_cnt !== 8'd2 || irq !== 1'b1) begin
      failures++;
      $display("FAIL rst_reprog got mask=%h cnt=%0d irq=%b required 50 2 1", mask, match_cnt, irq);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_cross_byte();
    test_len_limits();
    test_flush_and_irq();
    test_saturation();
    test_back_to_back_cfg_busy();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the match counter width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a data byte is offered.
REQ-005 The block SHALL have port in_data, input, 8 bits: the byte to scan, serialized MSB first.
REQ-006 The block SHALL have port in_ready, output, 1 bit: a byte is accepted when in_valid and in_ready are both 1.
REQ-007 The block SHALL have port cfg_we, input, 1 bit: a one-cycle configuration write strobe.
REQ-008 The block SHALL have port cfg_pattern, input, 8 bits: the target pattern; bit len-1 is the earliest bit in time.
REQ-009 The block SHALL have port cfg_len, input, 4 bits: the pattern length.
REQ-010 The block SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronously clears the bit history.
REQ-012 The block SHALL have port cnt_clr, input, 1 bit: synchronously clears match_cnt.
REQ-013 The block SHALL have port irq_ack, input, 1 bit: clears irq.
REQ-014 The block SHALL have port busy, output, 1 bit: 1 while in state SHIFT.
REQ-015 The block SHALL have port match, output, 1 bit: registered one-cycle pulse per detection.
REQ-016 The block SHALL have port match_cnt, output, CNT_W bits: saturating detection count.
REQ-017 The block SHALL have port irq, output, 1 bit: sticky detection flag.

Function
REQ-018 The FSM SHALL have two states, IDLE and SHIFT, with in_ready = (state==IDLE) and busy = (state==SHIFT).
REQ-019 In IDLE, a handshake SHALL latch in_data into the shift buffer, clear bit index k to 0, and move to SHIFT.
REQ-020 In SHIFT, each cycle SHALL consume bit in_data[7-k] and increment k; after k=7 the FSM SHALL return to IDLE, giving one byte per 9 cycles.
REQ-021 Each consumed bit SHALL update hist <= {hist[6:0], bit} and seen <= min(seen+1, 8).
REQ-022 Detection SHALL occur when len >= 1, the updated seen >= len, and the updated hist[len-1:0] equals pattern[len-1:0].
REQ-023 A detection SHALL assert match on the cycle after the bit's SHIFT cycle (1-cycle latency); match SHALL be 0 at all other times.
REQ-024 The effective length len SHALL equal cfg_len if 1..8, SHALL be 8 if cfg_len > 8, and len = 0 SHALL disable detection.
REQ-025 With overlap = 1, history SHALL be kept after a detection.
REQ-026 With overlap = 0, seen SHALL be forced to 0 on a detection.
REQ-027 History and seen SHALL persist across bytes, so patterns spanning byte boundaries are detected.
REQ-028 A cfg_we in IDLE SHALL register pattern, len and overlap and SHALL clear hist and seen.
REQ-029 A cfg_we in SHIFT SHALL be ignored entirely.
REQ-030 A flush SHALL clear hist and seen; if it coincides with a SHIFT bit, that bit SHALL be discarded and no detection SHALL occur.
REQ-031 match_cnt SHALL increment by 1 per detection and SHALL saturate at 2^CNT_W-1.
REQ-032 cnt_clr SHALL set match_cnt to 0; when cnt_clr coincides with a detection, the clear SHALL win (count 0) while match still pulses.
REQ-033 irq SHALL be set by a detection and cleared by irq_ack; when set and ack coincide, the set SHALL win.
REQ-034 in_valid without in_ready SHALL have no effect, and in_data SHALL only be sampled at the handshake.

Reset
REQ-035 On rst = 1, at any time including mid-SHIFT, the block SHALL immediately enter IDLE.
REQ-036 On reset, the partial byte SHALL be discarded, and k, hist, seen, match, match_cnt and irq SHALL be 0; in_ready SHALL be 1 and busy 0.
REQ-037 On reset, the configuration SHALL be pattern 0x00, len 0 (disabled), overlap 0.
REQ-038 After rst deasserts, the first handshake SHALL be accepted on the first rising edge.

Verification
REQ-039 Overlap test: cfg pattern 0x15, len 5, overlap 1; send 0xAA -> match pulses after bits 4 and 6 (k=4, k=6); match_cnt = 2; irq = 1.
REQ-040 Non-overlap test: same config with overlap 0; send 0xAA -> exactly one pulse, after k=4; match_cnt = 1.
REQ-041 Cross-byte test: cfg pattern 0x09, len 4; send 0x01 then 0x20 -> one pulse, after k=2 of the second byte; match_cnt = 1.
REQ-042 Saturation and clear test: cfg pattern 0x01, len 1; send 0xFF 32 times -> match_cnt = 255 and holds; then cnt_clr together with a detection -> match_cnt = 0 and match pulses.
REQ-043 Config-while-busy test: cfg_we with len 2 at k=3 of 0xAA under the REQ-039 config -> ignored; 2 detections still occur.
REQ-044 Reset mid-SHIFT test: rst at k=5 -> outputs reach reset values, in_ready = 1; after release, re-program and send 0xAA -> REQ-039 results.
